// File: rtl/display_pkg.sv
// Shared types and the hex-to-seven-segment table for the display path.
// Exports seg_t, the scan FSM state type, SEG_BLANK and hex_to_seg().
package display_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_DEAD,
    ST_ON
  } scan_state_e;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] v);
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/module_seg_encoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
// Ports: val_i (4-bit value), seg_o (seg_t {g,f,e,d,c,b,a}).
module module_seg_encoder
  import display_pkg::*;
(
  input  logic [3:0] val_i,
  output seg_t       seg_o
);

  assign seg_o = hex_to_seg(val_i);

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed N-digit seven-segment scanner with double buffering,
// dead time, per-digit blanking, leading-zero suppression, frame strobe.
// Ports: clk, rst_n (sync, active low), data_i/blank_i/load_i (pending
// buffer write), lz_en_i, seg_o/an_o (registered pins), frame_o, pending_o.
module module_display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_HZ         = 27_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEAD_CYCLES    = 64,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  load_i,
  input  logic                  lz_en_i,
  output logic [6:0]            seg_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o,
  output logic                  pending_o
);

  localparam int SLOT = CLK_HZ / (SCAN_HZ * N_DIGITS);
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int DW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DB   = 4 * N_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(DEAD_CYCLES);
  localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam seg_t SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  generate
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
      $error("N_DIGITS must be within 1..8");
    end
    if (SLOT < DEAD_CYCLES + 1) begin : g_bad_slot
      $error("slot too short for DEAD_CYCLES");
    end
  endgenerate

  scan_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [DB-1:0]       act_data_q, act_data_d;
  logic [N_DIGITS-1:0] act_blank_q, act_blank_d;
  logic [DB-1:0]       pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                pend_q, pend_d;
  logic                frame_q, frame_d;
  seg_t                seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                slot_end;
  logic                wrap;
  logic [N_DIGITS-1:0] lz_mask;
  logic [N_DIGITS-1:0] an_on;
  logic                cur_blank;
  logic [3:0]          cur_nib;
  seg_t                enc_seg;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (dig_q == DIG_LAST);

  // Counters, buffers and FSM next state
  always_comb begin
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    dig_d        = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    state_d      = (cnt_d >= CNT_ON) ? ST_ON : ST_DEAD;
    act_data_d   = act_data_q;
    act_blank_d  = act_blank_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_d       = pend_q;
    frame_d      = wrap;
    if (load_i) begin
      pend_data_d  = data_i;
      pend_blank_d = blank_i;
      pend_d       = 1'b1;
    end
    // A load on the wrap edge bypasses the pending buffer
    if (wrap) begin
      if (load_i) begin
        act_data_d  = data_i;
        act_blank_d = blank_i;
        pend_d      = 1'b0;
      end else if (pend_q) begin
        act_data_d  = pend_data_q;
        act_blank_d = pend_blank_q;
        pend_d      = 1'b0;
      end
    end
  end

  // A digit is lz-suppressed when it and every higher digit are zero
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run        = run && (act_data_d[4*k +: 4] == 4'h0);
      lz_mask[k] = run && (k != 0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    an_on     = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (dig_d == DW'(k)) begin
        cur_nib   = act_data_d[4*k +: 4];
        cur_blank = act_blank_d[k] || (lz_en_i && lz_mask[k]);
        an_on[k]  = 1'b1;
      end
    end
  end

  module_seg_encoder u_enc (
    .val_i (cur_nib),
    .seg_o (enc_seg)
  );

  // Pins only move on slot-phase boundaries; held otherwise
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (state_d == ST_DEAD && state_q == ST_ON) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else if (state_d == ST_ON &&
                 (state_q == ST_DEAD || cnt_d == CNT_ON)) begin
      if (cur_blank) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end else begin
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~enc_seg : enc_seg;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DEAD;
      cnt_q        <= '0;
      dig_q        <= '0;
      act_data_q   <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_q       <= 1'b0;
      frame_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      act_data_q   <= act_data_d;
      act_blank_q  <= act_blank_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_q       <= pend_d;
      frame_q      <= frame_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_o     = seg_q;
  assign an_o      = an_q;
  assign frame_o   = frame_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Randomised self-checking bench for module_display_scan against a
// frame/slot arithmetic model (SLOT=10, DEAD=2, 4 digits, 40-cycle frame).
module tb_module_display_scan;

  localparam int N     = 4;
  localparam int SLOT  = 10;
  localparam int DEAD  = 2;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_i;
  logic [3:0]  blank_i;
  logic        load_i;
  logic        lz_en_i;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_t;
  logic [15:0] m_ad, m_pd;
  logic [3:0]  m_ab, m_pb;
  logic        m_pf;

  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_frame, e_pend;

  logic [6:0] segs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  module_display_scan #(
    .N_DIGITS       (N),
    .CLK_HZ         (40_000),
    .SCAN_HZ        (1000),
    .DEAD_CYCLES    (DEAD),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .blank_i   (blank_i),
    .load_i    (load_i),
    .lz_en_i   (lz_en_i),
    .seg_o     (seg_o),
    .an_o      (an_o),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  task automatic predict();
    int c, d;
    logic [15:0] up;
    logic bl;
    c  = m_t % SLOT;
    d  = (m_t / SLOT) % N;
    up = m_ad >> (4 * d);
    bl = m_ab[d] || (lz_en_i && d != 0 && up == 16'h0);
    if (c < DEAD || bl) begin
      e_an  = 4'hF;
      e_seg = 7'h00;
    end else begin
      e_an  = ~(4'b0001 << d);
      e_seg = segs[up[3:0]];
    end
    e_frame = (m_t % FRAME == 0) && (m_t != 0);
    e_pend  = m_pf;
  endtask

  // Advance one clock, update the model with the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_t = 0; m_ad = '0; m_ab = '0; m_pd = '0; m_pb = '0; m_pf = 1'b0;
    end else begin
      if (load_i) begin
        m_pd = data_i; m_pb = blank_i; m_pf = 1'b1;
      end
      if (m_t % FRAME == FRAME - 1 && m_pf) begin
        m_ad = m_pd; m_ab = m_pb; m_pf = 1'b0;
      end
      m_t++;
    end
    #1;
    predict();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_i = 1'b0; lz_en_i = 1'b0;
    data_i = '0; blank_i = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== 13'b1111_0000000_0_0) begin
        n_fail++;
        $display("FAIL reset an=%b seg=%h fr=%b pend=%b req an=1111 seg=00 fr=0 pend=0",
                 an_o, seg_o, frame_o, pending_o);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL idle t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
  endtask

  task automatic test_load_mid();
    for (int i = 0; i < FRAME && (m_t % FRAME) != 5; i++) tick();
    data_i = 16'h1234; blank_i = '0; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    n_checks++;
    if (pending_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_pend pending_o=%b required 1", pending_o);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL load_mid t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
  endtask

  task automatic test_overwrite();
    for (int i = 0; i < 2 * FRAME; i++) begin
      load_i = 1'b0;
      if (m_t % FRAME == 3) begin data_i = 16'hAAAA; load_i = 1'b1; end
      if (m_t % FRAME == 20) begin data_i = 16'h00F0; load_i = 1'b1; end
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL overwrite t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
    load_i = 1'b0;
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
    lz_en_i = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 2 * FRAME; i++) begin
        load_i = (i == 0);
        data_i = vals[v];
        tick();
        n_checks++;
        if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
          n_fail++;
          $display("FAIL lz t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                   an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
        end
      end
    end
    load_i = 1'b0;
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
    lz_en_i = 1'b0;
  endtask

  task automatic test_wrap_load();
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
    data_i = 16'hBEEF; blank_i = 4'b1000; load_i = 1'b1;
    tick();
    load_i = 1'b0; blank_i = '0;
    n_checks++;
    if ({pending_o, frame_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL wrap_load pend=%b fr=%b required pend=0 fr=1", pending_o, frame_o);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL wrap_load t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < FRAME && (m_t % FRAME) != 26; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({an_o, seg_o} !== 11'b1111_0000000) begin
      n_fail++;
      $display("FAIL mid_reset an=%b seg=%h required an=1111 seg=00", an_o, seg_o);
    end
    for (int i = 0; i < FRAME + 5; i++) begin
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL mid_reset t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30 * FRAME; i++) begin
      load_i = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0) data_i = 16'($urandom);
      else data_i = 16'($urandom) & 16'h00FF;
      blank_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if (m_t % SLOT == SLOT - 1 && $urandom_range(0, 3) == 0) lz_en_i = ~lz_en_i;
      tick();
      n_checks++;
      if ({an_o, seg_o, frame_o, pending_o} !== {e_an, e_seg, e_frame, e_pend}) begin
        n_fail++;
        $display("FAIL random t=%0d an=%b/%b seg=%h/%h fr=%b/%b pend=%b/%b", m_t,
                 an_o, e_an, seg_o, e_seg, frame_o, e_frame, pending_o, e_pend);
      end
    end
    load_i = 1'b0;
  endtask

  initial begin
    m_t = 0; m_ad = '0; m_ab = '0; m_pd = '0; m_pb = '0; m_pf = 1'b0;
    test_reset();
    test_idle();
    test_load_mid();
    test_overwrite();
    test_lz();
    test_wrap_load();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
